cache_backing_mem: RTL and testbench

- Memory-side responder that services single-word read and write requests issued by the data cache on misses and write-throughs.
- Models main memory behind the cache:
  - valid/ready request channel in, valid/ready response channel out;
  - fixed, parameterised access latency.
- Sits directly below the data cache in the core's memory hierarchy.
- Doubles as the bench memory model for cache verification.

---
 rtl/cache_backing_mem.sv | 180 ++++++++++++++++++
 tb/tb_cache_backing_mem.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_backing_mem.sv
// cache_backing_mem: main-memory responder behind the data cache.
// Accepts one single-word read or write at a time over a valid/ready
// request channel and answers over a valid/ready response channel after
// a fixed, per-direction access latency. Misaligned or out-of-range
// addresses are answered with resp_err=1 and never touch the array.
// Optional feature macro: CACHE_BACKING_MEM_STATS_EN adds saturating
// 16-bit read/write/error response counters on three extra outputs.
module cache_backing_mem #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_LOG2    = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
`ifdef CACHE_BACKING_MEM_STATS_EN
  ,
  output logic [15:0]           stat_reads,
  output logic [15:0]           stat_writes,
  output logic [15:0]           stat_errors
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hDEADBEEF);
  localparam logic [3:0] RD_CNT_INIT = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_CNT_INIT = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   index;
  logic                    addr_err;
  logic                    mem_we;
  logic                    resp_hs;

  // Word index and error decode from the latched request address.
  assign index    = addr_q[DEPTH_LOG2+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) ||
                    ((addr_q >> (DEPTH_LOG2 + 2)) != '0);
  assign resp_hs  = (state_q == RESP) && resp_ready;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Next-state and datapath decode for the IDLE -> WAIT -> RESP handshake.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = req_write ? WR_CNT_INIT : RD_CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          err_d   = addr_err;
          if (wr_q) begin
            rdata_d = '0;
            mem_we  = !addr_err;
          end else begin
            rdata_d = addr_err ? ERR_RDATA : mem[index];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array write port; a reset edge suppresses a pending write.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset on purpose; contents survive reset and
    // a reset branch here would prevent mapping onto RAM.
    if (reset && mem_we) begin
      mem[index] <= wdata_q;
    end
  end

`ifdef CACHE_BACKING_MEM_STATS_EN
  logic [15:0] stat_reads_q, stat_writes_q, stat_errors_q;

  // Saturating per-kind response counters, bumped on each response handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_reads_q  <= 16'd0;
      stat_writes_q <= 16'd0;
      stat_errors_q <= 16'd0;
    end else if (resp_hs) begin
      if (err_q) begin
        if (stat_errors_q != 16'hFFFF) stat_errors_q <= stat_errors_q + 16'd1;
      end else if (wr_q) begin
        if (stat_writes_q != 16'hFFFF) stat_writes_q <= stat_writes_q + 16'd1;
      end else begin
        if (stat_reads_q != 16'hFFFF) stat_reads_q <= stat_reads_q + 16'd1;
      end
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_errors = stat_errors_q;
`else
  logic unused_hs;
  assign unused_hs = resp_hs;
`endif

endmodule

// File: tb/tb_cache_backing_mem.sv
// tb_cache_backing_mem: directed self-checking bench for cache_backing_mem
// with default parameters (READ_LATENCY=4, WRITE_LATENCY=2, DEPTH_LOG2=10).
// Stat counters are checked when CACHE_BACKING_MEM_STATS_EN is defined.
module tb_cache_backing_mem;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef CACHE_BACKING_MEM_STATS_EN
  logic [15:0] stat_reads;
  logic [15:0] stat_writes;
  logic [15:0] stat_errors;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  cache_backing_mem dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef CACHE_BACKING_MEM_STATS_EN
    ,
    .stat_reads (stat_reads),
    .stat_writes(stat_writes),
    .stat_errors(stat_errors)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for req_ready, present the request, return the accept-edge cycle.
  task automatic issue(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int acc);
    int n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    tick();
    acc = cyc;
    req_valid = 1'b0;
  endtask

  // Wait for resp_valid and check latency, data and error flag.
  task automatic await_resp(input string tag, input int acc, input int exp_lat,
                            input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    n = 0;
    while (!resp_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_latency"}, 32'(cyc - acc), 32'(exp_lat));
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
  endtask

  // Full transaction with resp_ready held high; checks the return to IDLE.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rdata,
                     input logic exp_err);
    int acc;
    issue(tag, w, a, d, acc);
    await_resp(tag, acc, w ? 2 : 4, exp_rdata, exp_err);
    tick();
    check({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int acc1, acc2;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    tick();

    // Write then read back.
    txn("wr10", 1'b1, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0);
    txn("rd10", 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Backpressure: hold resp_ready low for 5 cycles after resp_valid.
    resp_ready = 1'b0;
    issue("bp", 1'b0, 32'h10, 32'h0, acc1);
    await_resp("bp", acc1, 4, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_rdata", resp_rdata, 32'hCAFE_F00D);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    check("bp_rel_valid", 32'(resp_valid), 32'd0);
    check("bp_rel_ready", 32'(req_ready), 32'd1);
    check("bp_rel_rdata", resp_rdata, 32'd0);

    // Errors: word 0 must survive an out-of-range write aliasing onto it.
    txn("wr0", 1'b1, 32'h0, 32'hA5A5_0000, 32'h0, 1'b0);
    txn("err_rd", 1'b0, 32'h12, 32'h0, 32'hDEAD_BEEF, 1'b1);
    txn("err_wr", 1'b1, 32'h1000, 32'h5555_AAAA, 32'h0, 1'b1);
    txn("rd0", 1'b0, 32'h0, 32'h0, 32'hA5A5_0000, 1'b0);

    // Request held during busy: second read waits for the first handshake.
    txn("wr4", 1'b1, 32'h4, 32'h0000_0444, 32'h0, 1'b0);
    txn("wr8", 1'b1, 32'h8, 32'h0000_0888, 32'h0, 1'b0);
    issue("held1", 1'b0, 32'h4, 32'h0, acc1);
    req_valid = 1'b1;
    req_addr  = 32'h8;
    await_resp("held1", acc1, 4, 32'h0000_0444, 1'b0);
    issue("held2", 1'b0, 32'h8, 32'h0, acc2);
    check("held_spacing", 32'(acc2 - acc1), 32'd6);
    await_resp("held2", acc2, 4, 32'h0000_0888, 1'b0);
    tick();

    // Reset during WAIT drops a pending write.
    txn("wr20", 1'b1, 32'h20, 32'h1111_2222, 32'h0, 1'b0);
    issue("rstmid", 1'b1, 32'h20, 32'h1234_5678, acc1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_valid", 32'(resp_valid), 32'd0);
    repeat (3) tick();
    check("rstmid_valid_late", 32'(resp_valid), 32'd0);
    txn("rd20", 1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0);

    // Mixed traffic for the stat counters: 3 reads, 2 writes, 1 error.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    txn("st_wr30", 1'b1, 32'h30, 32'h0303_0303, 32'h0, 1'b0);
    txn("st_wr34", 1'b1, 32'h34, 32'h0343_4343, 32'h0, 1'b0);
    txn("st_rd30", 1'b0, 32'h30, 32'h0, 32'h0303_0303, 1'b0);
    txn("st_rd34", 1'b0, 32'h34, 32'h0, 32'h0343_4343, 1'b0);
    txn("st_rd10", 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0);
    txn("st_err", 1'b0, 32'h2, 32'h0, 32'hDEAD_BEEF, 1'b1);
`ifdef CACHE_BACKING_MEM_STATS_EN
    check("stat_reads", 32'(stat_reads), 32'd3);
    check("stat_writes", 32'(stat_writes), 32'd2);
    check("stat_errors", 32'(stat_errors), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("stat_reads_rst", 32'(stat_reads), 32'd0);
    check("stat_writes_rst", 32'(stat_writes), 32'd0);
    check("stat_errors_rst", 32'(stat_errors), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
